// File: rtl/ddc_frame_reader_if.sv
// AXI-Stream sample channel carrying {I,Q} baseband frames out of the DDC frame reader.
interface ddc_frame_reader_if;
  logic        tvalid;
  logic        tready;
  logic [31:0] tdata;
  logic        tlast;

  modport master (output tvalid, output tdata, output tlast, input tready);
  modport slave  (input tvalid, input tdata, input tlast, output tready);
endinterface

// File: rtl/ddc_frame_reader.sv
// Follows the DDC ring write pointer, reads whole frames from the ring RAM and
// streams them out over AXI-Stream with tlast on the final sample of each frame.
//
// state  | meaning
// IDLE   | stopped, waiting for enb
// ARM    | one cycle: jump read pointer to the write pointer, dropping stale data
// WAIT   | frame boundary: overflow check, then wait for a full frame of backlog
// READ   | issuing the FRAME_LEN reads of the current frame
module ddc_frame_reader #(
  parameter int FRAME_LEN  = 256,
  parameter int RD_LAT     = 2,
  parameter int MAX_ADDR   = 11520,
  parameter int OVF_MARGIN = 256
) (
  input  logic               lbs_clk,
  input  logic               rst,
  input  logic               enb,
  input  logic [13:0]        ddc_conv_waddr,
  output logic [13:0]        lbs_addr,
  input  logic [31:0]        ddc_conv_data,
  ddc_frame_reader_if.master m_axis,
  output logic [15:0]        frame_cnt,
  output logic               ovf_flag,
  input  logic               ovf_clr
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT, S_READ} state_t;

  localparam logic [14:0] RING     = 15'(MAX_ADDR + 1);
  localparam logic [14:0] OVF_TH   = 15'(MAX_ADDR + 1 - OVF_MARGIN);
  localparam logic [14:0] FRAME_W  = 15'(FRAME_LEN);
  localparam logic [12:0] LAST_IDX = 13'(FRAME_LEN - 1);
  localparam logic [13:0] MAX_A    = 14'(MAX_ADDR);

  state_t          state, state_nxt;
  logic [13:0]     raddr;
  logic [12:0]     issue_idx;
  logic [14:0]     avail;
  logic [RD_LAT:0] pipe_v, pipe_l;
  logic [32:0]     fifo_mem [4];
  logic [1:0]      wr_ptr, rd_ptr;
  logic [2:0]      fifo_count;
  logic [2:0]      inflight;
  logic [3:0]      occ;
  logic            push, pop, issue, issue_ok, resync, set_ovf, start_frame;

  always_comb begin
    if (ddc_conv_waddr >= raddr) avail = {1'b0, ddc_conv_waddr} - {1'b0, raddr};
    else                         avail = {1'b0, ddc_conv_waddr} + RING - {1'b0, raddr};
  end

  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + {2'b0, pipe_v[i]};
  end

  // A beat leaving this cycle frees its slot, so credit it to keep one sample/cycle.
  assign push     = pipe_v[RD_LAT];
  assign pop      = m_axis.tvalid & m_axis.tready;
  assign occ      = {1'b0, fifo_count} + {1'b0, inflight} - {3'b0, pop};
  assign issue_ok = (occ < 4'd4);

  always_comb begin
    state_nxt   = state;
    issue       = 1'b0;
    resync      = 1'b0;
    set_ovf     = 1'b0;
    start_frame = 1'b0;
    case (state)
      S_IDLE: if (enb) state_nxt = S_ARM;
      S_ARM: begin
        resync    = 1'b1;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (!enb) begin
          state_nxt = S_IDLE;
        end else if (avail > OVF_TH) begin
          set_ovf = 1'b1;
          resync  = 1'b1;
        end else if (avail >= FRAME_W) begin
          start_frame = 1'b1;
          state_nxt   = S_READ;
        end
      end
      S_READ: begin
        if (issue_ok) begin
          issue = 1'b1;
          if (issue_idx == LAST_IDX) state_nxt = S_WAIT;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge lbs_clk) begin
    if (rst) begin
      state     <= S_IDLE;
      raddr     <= '0;
      lbs_addr  <= '0;
      issue_idx <= '0;
      pipe_v    <= '0;
      pipe_l    <= '0;
      ovf_flag  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (resync)     raddr <= ddc_conv_waddr;
      else if (issue) raddr <= (raddr == MAX_A) ? 14'd0 : raddr + 14'd1;
      if (issue) lbs_addr <= raddr;
      if (start_frame) issue_idx <= '0;
      else if (issue)  issue_idx <= issue_idx + 13'd1;
      pipe_v <= {pipe_v[RD_LAT-1:0], issue};
      pipe_l <= {pipe_l[RD_LAT-1:0], issue && (issue_idx == LAST_IDX)};
      if (set_ovf)      ovf_flag <= 1'b1;
      else if (ovf_clr) ovf_flag <= 1'b0;
      if (pop && m_axis.tlast) frame_cnt <= frame_cnt + 16'd1;
    end
  end

  always_ff @(posedge lbs_clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop)  rd_ptr <= rd_ptr + 2'd1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 3'd1;
        2'b01:   fifo_count <= fifo_count - 3'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge lbs_clk) begin
    if (push) fifo_mem[wr_ptr] <= {pipe_l[RD_LAT], ddc_conv_data};
  end

  assign m_axis.tvalid = (fifo_count != 3'd0);
  assign m_axis.tdata  = m_axis.tvalid ? fifo_mem[rd_ptr][31:0] : 32'd0;
  assign m_axis.tlast  = m_axis.tvalid & fifo_mem[rd_ptr][32];

endmodule

// File: tb/tb_ddc_frame_reader.sv
// Bench for ddc_frame_reader: ring RAM model with data derived from address,
// scoreboard of expected {tlast,tdata} beats filled as frames are armed.
module tb_ddc_frame_reader;
  localparam int FRAME_LEN = 256;
  localparam int RD_LAT    = 2;
  localparam int MAX_ADDR  = 11520;
  localparam int RING      = MAX_ADDR + 1;

  logic        lbs_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enb = 1'b0;
  logic        ovf_clr = 1'b0;
  logic [13:0] waddr = '0;
  logic [13:0] lbs_addr;
  logic [31:0] ddc_conv_data;
  logic [15:0] frame_cnt;
  logic        ovf_flag;

  int          n_checks = 0;
  int          n_fail = 0;
  int          beats = 0;
  int          wr_left = 0;
  bit          rnd_ready = 1'b0;
  logic [32:0] sb_q [$];
  logic [13:0] ram_pipe [RD_LAT];
  bit          stall_pend = 1'b0;
  logic [31:0] held_d;
  logic        held_l;

  ddc_frame_reader_if m_axis_if ();

  ddc_frame_reader #(
    .FRAME_LEN(FRAME_LEN), .RD_LAT(RD_LAT), .MAX_ADDR(MAX_ADDR), .OVF_MARGIN(256)
  ) dut (
    .lbs_clk(lbs_clk), .rst(rst), .enb(enb), .ddc_conv_waddr(waddr),
    .lbs_addr(lbs_addr), .ddc_conv_data(ddc_conv_data), .m_axis(m_axis_if),
    .frame_cnt(frame_cnt), .ovf_flag(ovf_flag), .ovf_clr(ovf_clr)
  );

  always #5 lbs_clk = ~lbs_clk;

  function automatic logic [31:0] exp_data(input logic [13:0] a);
    return {{2'b0, a} ^ 16'hA5A5, {2'b0, a}};
  endfunction

  always @(posedge lbs_clk) begin
    ram_pipe[0] <= lbs_addr;
    for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
  end
  assign ddc_conv_data = exp_data(ram_pipe[RD_LAT-1]);

  // Scoreboard pop and stall-hold check, sampled mid-cycle.
  always @(negedge lbs_clk) begin
    logic [32:0] e;
    if (!rst) begin
      if (stall_pend) begin
        n_checks++;
        if (m_axis_if.tvalid !== 1'b1 || m_axis_if.tdata !== held_d || m_axis_if.tlast !== held_l) begin
          n_fail++;
          $display("FAIL stall_hold: got v=%b d=%h l=%b, want v=1 d=%h l=%b",
                   m_axis_if.tvalid, m_axis_if.tdata, m_axis_if.tlast, held_d, held_l);
        end
      end
      if (m_axis_if.tvalid && m_axis_if.tready) begin
        n_checks++;
        beats++;
        if (sb_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_beat: got d=%h l=%b, want no beat", m_axis_if.tdata, m_axis_if.tlast);
        end else begin
          e = sb_q.pop_front();
          if ({m_axis_if.tlast, m_axis_if.tdata} !== e) begin
            n_fail++;
            $display("FAIL beat: got l=%b d=%h, want l=%b d=%h",
                     m_axis_if.tlast, m_axis_if.tdata, e[32], e[31:0]);
          end
        end
      end
      stall_pend = m_axis_if.tvalid && !m_axis_if.tready;
      held_d     = m_axis_if.tdata;
      held_l     = m_axis_if.tlast;
    end else begin
      stall_pend = 1'b0;
    end
  end

  task automatic tick();
    @(posedge lbs_clk);
    #1;
    if (wr_left > 0) begin
      waddr = (waddr == 14'(MAX_ADDR)) ? 14'd0 : waddr + 14'd1;
      wr_left--;
    end
    if (rnd_ready) m_axis_if.tready = 1'($urandom_range(0, 1));
  endtask

  task automatic do_reset();
    rst = 1'b1; enb = 1'b0; ovf_clr = 1'b0; wr_left = 0;
    repeat (3) tick();
    rst = 1'b0;
    sb_q.delete();
    beats = 0;
  endtask

  task automatic push_frame(input int start);
    for (int i = 0; i < FRAME_LEN; i++) begin
      int a;
      a = (start + i) % RING;
      sb_q.push_back({(i == FRAME_LEN - 1), exp_data(14'(a))});
    end
  endtask

  task automatic arm_at(input logic [13:0] w);
    wr_left = 0;
    waddr = w;
    enb = 1'b1;
    repeat (3) tick();
    push_frame(int'(w));
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin tick(); n++; end
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d beats outstanding, want 0", name, sb_q.size());
    end
  endtask

  task automatic wait_beats(input int target, input int budget);
    int n = 0;
    while (beats < target && n < budget) begin tick(); n++; end
    n_checks++;
    if (beats < target) begin
      n_fail++;
      $display("FAIL beat_wait: got %0d beats, want %0d", beats, target);
    end
  endtask

  task automatic test_reset();
    m_axis_if.tready = 1'b1;
    do_reset();
    @(negedge lbs_clk);
    n_checks++;
    if ({m_axis_if.tvalid, m_axis_if.tlast, m_axis_if.tdata} !== 34'd0) begin
      n_fail++;
      $display("FAIL reset_axis: got v=%b l=%b d=%h, want 0", m_axis_if.tvalid, m_axis_if.tlast, m_axis_if.tdata);
    end
    n_checks++;
    if (lbs_addr !== 14'd0 || frame_cnt !== 16'd0 || ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_regs: got addr=%0d cnt=%0d ovf=%b, want 0 0 0", lbs_addr, frame_cnt, ovf_flag);
    end
  endtask

  task automatic test_single_frame();
    arm_at(14'd0);
    wr_left = 300;
    drain(2000, "single");
    repeat (3) tick();
    @(negedge lbs_clk);
    n_checks++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL single_frame_cnt: got %0d, want 1", frame_cnt);
    end
    enb = 1'b0;
  endtask

  task automatic test_random_ready();
    do_reset();
    arm_at(14'd500);
    push_frame(500 + FRAME_LEN);
    push_frame(500 + 2 * FRAME_LEN);
    wr_left = 3 * FRAME_LEN + 200;
    rnd_ready = 1'b1;
    drain(8000, "random");
    rnd_ready = 1'b0;
    m_axis_if.tready = 1'b1;
    repeat (20) tick();
    @(negedge lbs_clk);
    n_checks++;
    if (frame_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL random_frame_cnt: got %0d, want 3", frame_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    arm_at(14'd11400);
    wr_left = 300;
    drain(2000, "wrap");
    repeat (3) tick();
    @(negedge lbs_clk);
    n_checks++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL wrap_frame_cnt: got %0d, want 1", frame_cnt);
    end
  endtask

  task automatic test_overflow();
    int n = 0;
    do_reset();
    m_axis_if.tready = 1'b0;
    arm_at(14'd0);
    wr_left = RING + 100;
    while (wr_left > 0 && n < 13000) begin tick(); n++; end
    @(negedge lbs_clk);
    n_checks++;
    if (ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_mid_frame: got %b, want 0", ovf_flag);
    end
    m_axis_if.tready = 1'b1;
    drain(1000, "ovf_frame");
    repeat (3) tick();
    @(negedge lbs_clk);
    n_checks++;
    if (ovf_flag !== 1'b1 || frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL ovf_set: got ovf=%b cnt=%0d, want 1 1", ovf_flag, frame_cnt);
    end
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    tick();
    @(negedge lbs_clk);
    n_checks++;
    if (ovf_flag !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: got %b, want 0", ovf_flag);
    end
    push_frame(100);
    wr_left = 300;
    drain(2000, "resync");
    repeat (3) tick();
    @(negedge lbs_clk);
    n_checks++;
    if (frame_cnt !== 16'd2) begin
      n_fail++;
      $display("FAIL resync_frame_cnt: got %0d, want 2", frame_cnt);
    end
    tick();
    waddr = 14'((100 + FRAME_LEN + 11300) % RING);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge lbs_clk);
    n_checks++;
    if (ovf_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_set_vs_clr: got %b, want 1", ovf_flag);
    end
    repeat (5) tick();
    @(negedge lbs_clk);
    n_checks++;
    if (ovf_flag !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got %b, want 1", ovf_flag);
    end
  endtask

  task automatic test_enb_drop();
    do_reset();
    m_axis_if.tready = 1'b1;
    arm_at(14'd0);
    wr_left = 600;
    wait_beats(100, 1000);
    enb = 1'b0;
    drain(1000, "enb_drop");
    repeat (3) tick();
    @(negedge lbs_clk);
    n_checks++;
    if (frame_cnt !== 16'd1 || lbs_addr !== 14'd255) begin
      n_fail++;
      $display("FAIL enb_drop_done: got cnt=%0d addr=%0d, want 1 255", frame_cnt, lbs_addr);
    end
    repeat (50) tick();
    @(negedge lbs_clk);
    n_checks++;
    if (lbs_addr !== 14'd255 || m_axis_if.tvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL enb_drop_idle: got addr=%0d v=%b, want 255 0", lbs_addr, m_axis_if.tvalid);
    end
  endtask

  task automatic test_reset_mid();
    beats = 0;
    m_axis_if.tready = 1'b1;
    arm_at(waddr);
    wr_left = 400;
    wait_beats(50, 1000);
    rst = 1'b1;
    enb = 1'b0;
    wr_left = 0;
    tick();
    @(negedge lbs_clk);
    n_checks++;
    if (m_axis_if.tvalid !== 1'b0 || frame_cnt !== 16'd0 || lbs_addr !== 14'd0) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b cnt=%0d addr=%0d, want 0 0 0", m_axis_if.tvalid, frame_cnt, lbs_addr);
    end
    sb_q.delete();
    tick();
    rst = 1'b0;
    arm_at(waddr);
    wr_left = 300;
    drain(2000, "rearm");
    repeat (3) tick();
    @(negedge lbs_clk);
    n_checks++;
    if (frame_cnt !== 16'd1) begin
      n_fail++;
      $display("FAIL rearm_frame_cnt: got %0d, want 1", frame_cnt);
    end
  endtask

  initial begin
    m_axis_if.tready = 1'b1;
    test_reset();
    test_single_frame();
    test_random_ready();
    test_wrap();
    test_overflow();
    test_enb_drop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: got no end of test, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
